// File: rtl/sbit_frame_emulator_pkg.sv
// Shared constants for the S-bit frame emulator: state encoding, pattern
// select codes, frame geometry and the PRBS7 seed/step helper.
package sbit_frame_emulator_pkg;

  localparam int FRAME_BITS = 8;
  localparam int NUM_LANES  = 8;
  localparam int DATA_W     = NUM_LANES * FRAME_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [1:0] PAT_USER = 2'd0;
  localparam logic [1:0] PAT_WALK = 2'd1;
  localparam logic [1:0] PAT_ONES = 2'd2;
  localparam logic [1:0] PAT_PRBS = 2'd3;

  localparam logic [6:0] PRBS_SEED = 7'h7F;

  // Advance a PRBS7 (x^7+x^6+1) register by one frame. Returns
  // {word, next_state}; word bit 0 is the first (oldest) generated bit.
  function automatic logic [14:0] prbs7_step8(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] w;
    s = seed;
    w = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      w[i] = s[6] ^ s[5];
      s    = {s[5:0], w[i]};
    end
    return {w, s};
  endfunction

endpackage

// File: rtl/sbit_frame_emulator_if.sv
// Control/data bundle for the S-bit frame emulator. master drives the
// configuration and user S-bits, slave is the emulator itself.
interface sbit_frame_emulator_if;
  import sbit_frame_emulator_pkg::*;

  logic              enable_i;
  logic [DATA_W-1:0] sbits_i;
  logic [1:0]        pattern_sel_i;
  logic [2:0]        phase_i;
  logic [11:0]       sync_frames_i;
  logic              glitch_i;

  logic [DATA_W-1:0] sbits_o;
  logic [7:0]        start_of_frame_o;
  logic [1:0]        state_o;
  logic [15:0]       glitch_cnt_o;

  modport master (
    output enable_i, sbits_i, pattern_sel_i, phase_i, sync_frames_i, glitch_i,
    input  sbits_o, start_of_frame_o, state_o, glitch_cnt_o
  );

  modport slave (
    input  enable_i, sbits_i, pattern_sel_i, phase_i, sync_frames_i, glitch_i,
    output sbits_o, start_of_frame_o, state_o, glitch_cnt_o
  );
endinterface

// File: rtl/sbit_frame_emulator_bit_delay.sv
// sbit_bit_delay: emulated bit skew for one 8-bit-time frame. The output
// frame is the concatenation {cur, prev} viewed through a window shifted
// by `phase` bit-times, so late bits spill over from the previous frame.
module sbit_bit_delay #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] cur_word,
  input  logic [WIDTH-1:0] prev_word,
  input  logic [PW-1:0]    phase,
  output logic [WIDTH-1:0] out_word
);

  logic [2*WIDTH-1:0] cat;
  assign cat = {cur_word, prev_word};

  // out[b] = cur[b-p] for b>=p, prev[b-p+WIDTH] otherwise
  always_comb begin
    out_word = '0;
    for (int b = 0; b < WIDTH; b++)
      out_word[b] = cat[b + WIDTH - int'(phase)];
  end

endmodule

// File: rtl/sbit_frame_emulator.sv
// S-bit frame emulator: IDLE/SYNC/RUN sequencer producing framed, skewed
// S-bit words and a start-of-frame marker, with marker-glitch injection.
// Two-stage pipeline: pre-skew words are registered, then skewed against
// the previous pre-skew word and registered again at the outputs.
// Optional build macro SBIT_EMU_PRBS_EN enables the PRBS7 pattern (3);
// without it pattern 3 emits zeros.
module sbit_frame_emulator
  import sbit_frame_emulator_pkg::*;
(
  input  logic clock,
  input  logic reset,
  sbit_frame_emulator_if.slave emu
);

  logic [1:0]  state, state_nx;
  logic [11:0] sync_cnt, sync_lim;
  logic        sync_last, glitch_acc;
  logic [2:0]  phase_q, walk_k;
  logic [15:0] glitch_cnt;
  logic [7:0]  walk_byte, sof_c;
  logic [DATA_W-1:0] data_c;

  logic [NUM_LANES-1:0][FRAME_BITS-1:0] pre_data, hist_data, skew_data, out_data;
  logic [7:0] pre_sof, hist_sof, skew_sof, out_sof;

`ifdef SBIT_EMU_PRBS_EN
  logic [6:0] prbs_q, prbs_nx;
  logic [7:0] prbs_word;

  // one frame's worth of PRBS bits from the current register
  always_comb {prbs_word, prbs_nx} = prbs7_step8(prbs_q);
`endif

  assign sync_lim   = (emu.sync_frames_i == 12'd0) ? 12'd1 : emu.sync_frames_i;
  assign sync_last  = (sync_cnt >= sync_lim - 12'd1);
  assign glitch_acc = emu.glitch_i && (state != ST_IDLE);
  assign walk_byte  = 8'h01 << walk_k;

  // sequencer next state; enable low wins from any state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (emu.enable_i) state_nx = ST_SYNC;
      ST_SYNC: if (sync_last)    state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
    if (!emu.enable_i) state_nx = ST_IDLE;
  end

  // pre-skew data and marker for the current frame
  always_comb begin
    data_c = '0;
    if (state == ST_RUN) begin
      case (emu.pattern_sel_i)
        PAT_USER: data_c = emu.sbits_i;
        PAT_WALK: data_c = {NUM_LANES{walk_byte}};
        PAT_ONES: data_c = '1;
`ifdef SBIT_EMU_PRBS_EN
        PAT_PRBS: data_c = {NUM_LANES{prbs_word}};
`else
        PAT_PRBS: data_c = '0;
`endif
        default:  data_c = '0;
      endcase
    end
    sof_c = (state == ST_IDLE || glitch_acc) ? 8'h00 : 8'h01;
  end

  // sequencer state, sync counter, latched phase, pattern generators
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      sync_cnt   <= '0;
      phase_q    <= '0;
      walk_k     <= '0;
      glitch_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && state_nx == ST_SYNC) begin
        phase_q  <= emu.phase_i;
        sync_cnt <= '0;
      end else if (state == ST_SYNC) begin
        sync_cnt <= sync_cnt + 12'd1;
      end
      if (state != ST_RUN && state_nx == ST_RUN) walk_k <= '0;
      else if (state == ST_RUN)                  walk_k <= walk_k + 3'd1;
      if (glitch_acc && glitch_cnt != 16'hFFFF)  glitch_cnt <= glitch_cnt + 16'd1;
    end
  end

`ifdef SBIT_EMU_PRBS_EN
  // PRBS reseeds on RUN entry and advances one frame per RUN cycle
  always_ff @(posedge clock) begin
    if (reset)                                    prbs_q <= PRBS_SEED;
    else if (state != ST_RUN && state_nx == ST_RUN) prbs_q <= PRBS_SEED;
    else if (state == ST_RUN)                     prbs_q <= prbs_nx;
  end
`endif

  // input stage, history and output stage of the frame pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_data  <= '0;
      pre_sof   <= '0;
      hist_data <= '0;
      hist_sof  <= '0;
      out_data  <= '0;
      out_sof   <= '0;
    end else begin
      pre_data  <= data_c;
      pre_sof   <= sof_c;
      hist_data <= pre_data;
      hist_sof  <= pre_sof;
      out_data  <= skew_data;
      out_sof   <= skew_sof;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sbit_bit_delay #(.WIDTH(FRAME_BITS)) u_delay (
      .cur_word  (pre_data[l]),
      .prev_word (hist_data[l]),
      .phase     (phase_q),
      .out_word  (skew_data[l])
    );
  end

  sbit_bit_delay #(.WIDTH(FRAME_BITS)) u_sof_delay (
    .cur_word  (pre_sof),
    .prev_word (hist_sof),
    .phase     (phase_q),
    .out_word  (skew_sof)
  );

  assign emu.sbits_o          = out_data;
  assign emu.start_of_frame_o = out_sof;
  assign emu.state_o          = state;
  assign emu.glitch_cnt_o     = glitch_cnt;

endmodule

// File: tb/tb_sbit_frame_emulator.sv
// Directed bench for sbit_frame_emulator: sequencing, skew, patterns,
// glitch injection and reset, against hand-computed values.
module tb_sbit_frame_emulator;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;

  sbit_frame_emulator_if bus();

  sbit_frame_emulator dut (
    .clock (clock),
    .reset (reset),
    .emu   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  // drop enable, set config, re-raise and wait until RUN; returns the
  // number of cycles from enable to RUN, leaves the first RUN word visible
  task automatic run_start(input logic [2:0] p, input logic [1:0] pat,
                           input logic [11:0] nsync, output int cyc);
    bus.enable_i = 1'b0;
    tick();
    tick();
    bus.phase_i       = p;
    bus.pattern_sel_i = pat;
    bus.sync_frames_i = nsync;
    bus.enable_i      = 1'b1;
    cyc = 0;
    while (bus.state_o !== 2'd2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reach_run", {62'd0, bus.state_o}, 64'd2);
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] wexp;
    reset             = 1'b1;
    bus.enable_i      = 1'b0;
    bus.sbits_i       = '0;
    bus.pattern_sel_i = 2'd0;
    bus.phase_i       = 3'd0;
    bus.sync_frames_i = 12'd0;
    bus.glitch_i      = 1'b0;
    tick();
    tick();
    chk("rst_state", {62'd0, bus.state_o}, 64'd0);
    chk("rst_sbits", bus.sbits_o, 64'd0);
    chk("rst_sof",   {56'd0, bus.start_of_frame_o}, 64'd0);
    chk("rst_gcnt",  {48'd0, bus.glitch_cnt_o}, 64'd0);

    // basic bring-up: 4 SYNC frames, user pattern, phase 0
    reset             = 1'b0;
    bus.sbits_i       = 64'hA5;
    bus.sync_frames_i = 12'd4;
    bus.enable_i      = 1'b1;
    tick();
    chk("sync_t1", {62'd0, bus.state_o}, 64'd1);
    chk("sof_t1",  {56'd0, bus.start_of_frame_o}, 64'd0);
    tick();
    chk("sync_t2", {62'd0, bus.state_o}, 64'd1);
    tick();
    chk("sync_t3", {62'd0, bus.state_o}, 64'd1);
    chk("sof_t3",  {56'd0, bus.start_of_frame_o}, 64'd1);
    tick();
    chk("sync_t4", {62'd0, bus.state_o}, 64'd1);
    tick();
    chk("run_t5",  {62'd0, bus.state_o}, 64'd2);
    chk("data_t5", bus.sbits_o, 64'd0);
    tick();
    chk("data_t6", bus.sbits_o, 64'd0);
    tick();
    chk("data_t7", bus.sbits_o, 64'hA5);
    chk("sof_t7",  {56'd0, bus.start_of_frame_o}, 64'd1);

    // sync_frames 0 behaves as 1; 4 gives 4 SYNC frames
    run_start(3'd0, 2'd0, 12'd0, n);
    chk("sync0_len", 64'(n), 64'd2);
    run_start(3'd0, 2'd0, 12'd4, n);
    chk("sync4_len", 64'(n), 64'd5);

    // walking one, wraps after 8 frames
    run_start(3'd0, 2'd1, 12'd2, n);
    for (int i = 0; i < 9; i++) begin
      wexp = 8'h01 << (i % 8);
      chk("walk", bus.sbits_o, rep(wexp));
      tick();
    end

    // all-ones with phase 3
    run_start(3'd3, 2'd2, 12'd4, n);
    chk("ones_first", bus.sbits_o, rep(8'hF8));
    chk("ones_sof",   {56'd0, bus.start_of_frame_o}, 64'h08);
    tick();
    chk("ones_steady", bus.sbits_o, rep(8'hFF));
    chk("ones_sof2",   {56'd0, bus.start_of_frame_o}, 64'h08);

    // glitch pulse with phase 2
    run_start(3'd2, 2'd0, 12'd2, n);
    chk("g_sof_pre", {56'd0, bus.start_of_frame_o}, 64'h04);
    bus.glitch_i = 1'b1;
    tick();
    bus.glitch_i = 1'b0;
    chk("g_sof_0", {56'd0, bus.start_of_frame_o}, 64'h04);
    tick();
    chk("g_sof_1", {56'd0, bus.start_of_frame_o}, 64'h00);
    chk("g_cnt1",  {48'd0, bus.glitch_cnt_o}, 64'd1);
    tick();
    chk("g_sof_2", {56'd0, bus.start_of_frame_o}, 64'h04);
    // held glitch counts every cycle
    bus.glitch_i = 1'b1;
    tick();
    tick();
    tick();
    bus.glitch_i = 1'b0;
    chk("g_hold_cnt", {48'd0, bus.glitch_cnt_o}, 64'd4);
    chk("g_hold_sof", {56'd0, bus.start_of_frame_o}, 64'h00);
    // glitch in IDLE ignored
    bus.enable_i = 1'b0;
    tick();
    tick();
    bus.glitch_i = 1'b1;
    tick();
    bus.glitch_i = 1'b0;
    tick();
    chk("g_idle_cnt", {48'd0, bus.glitch_cnt_o}, 64'd4);

    // phase change only takes effect on a new IDLE->SYNC
    run_start(3'd0, 2'd2, 12'd3, n);
    chk("ph0_sof", {56'd0, bus.start_of_frame_o}, 64'h01);
    bus.phase_i = 3'd5;
    tick();
    tick();
    tick();
    chk("ph_live_sof",  {56'd0, bus.start_of_frame_o}, 64'h01);
    chk("ph_live_data", bus.sbits_o, rep(8'hFF));
    run_start(3'd5, 2'd2, 12'd3, n);
    chk("ph5_sof",   {56'd0, bus.start_of_frame_o}, 64'h20);
    chk("ph5_first", bus.sbits_o, rep(8'hE0));
    tick();
    chk("ph5_steady", bus.sbits_o, rep(8'hFF));

    // pattern 3: PRBS7 first frame from seed 7F is 8'h40, else zeros
    run_start(3'd0, 2'd3, 12'd1, n);
`ifdef SBIT_EMU_PRBS_EN
    chk("prbs_first", bus.sbits_o, rep(8'h40));
`else
    chk("prbs_off", bus.sbits_o, 64'd0);
`endif

    // reset mid-RUN
    run_start(3'd0, 2'd2, 12'd1, n);
    reset = 1'b1;
    tick();
    chk("mrst_state", {62'd0, bus.state_o}, 64'd0);
    chk("mrst_data",  bus.sbits_o, 64'd0);
    chk("mrst_sof",   {56'd0, bus.start_of_frame_o}, 64'd0);
    chk("mrst_gcnt",  {48'd0, bus.glitch_cnt_o}, 64'd0);
    reset = 1'b0;
    tick();
    chk("mrst_after", bus.sbits_o, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
